// File: rtl/sign_extension.sv
// Immediate generator for the RV32I decode stage.
// Selects I/S/B/U/J format by opcode and registers the sign-extended result.
package pkg_config;
    localparam int INST_WIDTH = 32;
    localparam int OPCODE     = 7;

    localparam logic [OPCODE-1:0] OP_ALUI   = 7'b0010011;
    localparam logic [OPCODE-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPCODE-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE-1:0] OP_ALU    = 7'b0110011;
endpackage

module sign_extension
    import pkg_config::*;
(
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [INST_WIDTH-1:0] inst_i,
    input  logic [OPCODE-1:0]     opcode_i,
    output logic [INST_WIDTH-1:0] immediate_extended_o
);

    logic [INST_WIDTH-1:0] imm_i;
    logic [INST_WIDTH-1:0] imm_s;
    logic [INST_WIDTH-1:0] imm_b;
    logic [INST_WIDTH-1:0] imm_u;
    logic [INST_WIDTH-1:0] imm_j;
    logic [INST_WIDTH-1:0] imm_next;
    logic                  sign;
    logic                  unused_opcode_bits;

    // The decoder owns the opcode; the instruction's own opcode field is ignored.
    assign unused_opcode_bits = ^inst_i[6:0];

    assign sign = inst_i[31];

    assign imm_i = {{20{sign}}, inst_i[31:20]};
    assign imm_s = {{20{sign}}, inst_i[31:25], inst_i[11:7]};
    assign imm_b = {{19{sign}}, inst_i[31], inst_i[7],
                    inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u = {inst_i[31:12], 12'h000};
    assign imm_j = {{11{sign}}, inst_i[31], inst_i[19:12],
                    inst_i[20], inst_i[30:21], 1'b0};

    always_comb begin
        imm_next = '0;
        unique case (opcode_i)
            OP_ALUI,
            OP_LOAD,
            OP_JALR:   imm_next = imm_i;
            OP_STORE:  imm_next = imm_s;
            OP_BRANCH: imm_next = imm_b;
            OP_LUI,
            OP_AUIPC:  imm_next = imm_u;
            OP_JAL:    imm_next = imm_j;
            default:   imm_next = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            immediate_extended_o <= '0;
        end else begin
            immediate_extended_o <= imm_next;
        end
    end

endmodule

// File: tb/tb_sign_extension.sv
// Randomised and directed bench for sign_extension.
// Reference model rebuilds immediates with shifts and masks.
module tb_sign_extension;
    import pkg_config::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [31:0] imm;

    int checks = 0;
    int errors = 0;
    logic [31:0] prev_exp;

    sign_extension dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .inst_i               (inst),
        .opcode_i             (opcode),
        .immediate_extended_o (imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] w,
                                          input logic [6:0] op);
        int          s;
        logic [31:0] ext;
        logic [31:0] top;
        s   = int'(w);
        ext = s >>> 31;
        case (op)
            7'b0010011, 7'b0000011, 7'b1100111: begin
                top = s >>> 20;
                return top;
            end
            7'b0100011: begin
                top = s >>> 25;
                return (top << 5) | ((w >> 7) & 32'h1F);
            end
            7'b1100011:
                return (ext << 12) | (((w >> 7) & 32'h1) << 11)
                     | (((w >> 25) & 32'h3F) << 5)
                     | (((w >> 8) & 32'hF) << 1);
            7'b0110111, 7'b0010111:
                return w & 32'hFFFF_F000;
            7'b1101111:
                return (ext << 20) | (((w >> 12) & 32'hFF) << 12)
                     | (((w >> 20) & 32'h1) << 11)
                     | (((w >> 21) & 32'h3FF) << 1);
            default:
                return 32'h0;
        endcase
    endfunction

    // Drive at negedge, confirm the old value holds, then check one edge later.
    task automatic apply(input string tag, input logic [31:0] w,
                         input logic [6:0] op, input logic [31:0] exp);
        @(negedge clk);
        inst   = w;
        opcode = op;
        #1;
        check({tag, "_hold"}, imm, prev_exp);
        @(posedge clk);
        #1;
        check(tag, imm, exp);
        prev_exp = exp;
    endtask

    logic [6:0] ops [10];

    initial begin
        ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                7'b0110011, 7'b1110011};

        rst_n  = 1'b0;
        inst   = 32'hFFFF_FFFF;
        opcode = 7'b0110111;
        #2;
        check("reset_async", imm, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_held", imm, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", imm, 32'hFFFF_F000);
        prev_exp = 32'hFFFF_F000;

        apply("i_alui",   32'h8000_0000, 7'b0010011, 32'hFFFF_F800);
        apply("i_load",   32'h1010_0000, 7'b0000011, 32'h0000_0101);
        apply("i_jalr",   32'h00C0_0167, 7'b1100111, 32'h0000_000C);
        apply("s_neg",    32'h80F8_0023, 7'b0100011, 32'hFFFF_F800);
        apply("s_zero",   32'h00F8_0023, 7'b0100011, 32'h0000_0000);
        apply("u_lui",    32'h0001_70B7, 7'b0110111, 32'h0001_7000);
        apply("u_auipc",  32'h0001_70B7, 7'b0010111, 32'h0001_7000);
        apply("j_pos",    32'h0E80_026F, 7'b1101111, 32'h0000_00E8);
        apply("j_neg",    32'hF19F_F26F, 7'b1101111, 32'hFFFF_FF18);
        apply("b_neg",    32'hFE41_04E3, 7'b1100011, 32'hFFFF_FFE8);
        apply("def_alu",  32'hFFFF_FFFF, 7'b0110011, 32'h0000_0000);
        apply("mismatch", 32'h8000_0033, 7'b0010011, 32'hFFFF_F800);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] w;
            logic [6:0]  op;
            int          k;
            w  = $urandom;
            k  = $urandom_range(0, 10);
            op = (k == 10) ? 7'($urandom) : ops[k];
            apply("random", w, op, model(w, op));
        end

        apply("pre_rst", 32'hFFFF_FFFF, 7'b0010011, 32'hFFFF_FFFF);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_async", imm, 32'h0);
        @(negedge clk);
        inst   = 32'h0E80_026F;
        opcode = 7'b1101111;
        rst_n  = 1'b1;
        #1;
        check("mid_reset_hold", imm, 32'h0);
        @(posedge clk);
        #1;
        check("mid_reset_release", imm, 32'h0000_00E8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/sign_extension.md
Name: sign_extension

Overview:
- Immediate generator for the RV32I core's decode stage.
- From the 32-bit instruction word and a separately supplied 7-bit opcode, it selects the immediate format (I, S, B, U, J) and assembles the immediate.
- It sign-extends the immediate to 32 bits and presents it registered to the execute stage.
- The opcode comes from the decoder; the block does not derive it from inst_i[6:0].

Parameters:
- INST_WIDTH, 32, instruction and immediate width in bits (package constant; only 32 supported).
- OPCODE, 7, opcode field width in bits (package constant).

Ports:
- clk_i  input  1  system clock; rising-edge active.
- rst_ni  input  1  asynchronous, active-low reset.
- inst_i  input  INST_WIDTH  full instruction word.
- opcode_i  input  OPCODE  decoded opcode, compared against the package opcode constants.
- immediate_extended_o  output  INST_WIDTH  sign-extended immediate, registered.

Behaviour:
- One clock; reset is asynchronous and active-low.
- While rst_ni=0: immediate_extended_o=32'h0000_0000 immediately, independent of clk_i.
- After rst_ni deasserts: output updates on each rising clk_i edge.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear at the output after edge N, and are held until the next edge.
- No handshake. The output register loads every cycle.
- Format selection by opcode_i (values from pkg_config):
  - OP_ALUI (0010011), OP_LOAD (0000011), OP_JALR (1100111) -> I-type: {{20{inst[31]}}, inst[31:20]}.
  - OP_STORE (0100011) -> S-type: {{20{inst[31]}}, inst[31:25], inst[11:7]}.
  - OP_BRANCH (1100011) -> B-type: {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - OP_LUI (0110111), OP_AUIPC (0010111) -> U-type: {inst[31:12], 12'h000}.
  - OP_JAL (1101111) -> J-type: {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - Any other opcode (R-type OP_ALU, SYSTEM, FENCE, illegal) -> 32'h0000_0000.
- Sign bit is always inst[31]. B and J bit 0 is forced to 0.
- ALUI shift instructions are not special-cased: the full 12-bit I-immediate is produced; shamt/funct7 interpretation belongs downstream.
- inst_i[6:0] is ignored; only opcode_i selects the format, even if the two disagree.
- Reset asserted mid-stream clears the output asynchronously. The first edge after release loads the current inputs.
- The next-value logic is purely combinational with no internal state beyond the output register.

Test Plan:
- Reset: hold rst_ni=0 with inst_i=32'hFFFF_FFFF, opcode_i=OP_LUI -> output 32'h0 throughout; after release and one edge -> 32'hFFFF_F000.
- I-type:
  - inst 32'h8000_0000, OP_ALUI -> 32'hFFFF_F800.
  - inst 32'h1010_0000, OP_LOAD -> 32'h0000_0101.
  - inst 32'h00C0_0167, OP_JALR -> 32'h0000_000C.
  - Each value is required one edge after the inputs are applied.
- S-type:
  - inst 32'h80F8_0023, OP_STORE -> 32'hFFFF_F800.
  - inst 32'h00F8_0023, OP_STORE -> 32'h0000_0000.
- U-type: inst 32'h0001_70B7 with OP_LUI -> 32'h0001_7000; same inst with OP_AUIPC -> 32'h0001_7000.
- J/B-type:
  - inst 32'h0E80_026F, OP_JAL -> 32'h0000_00E8.
  - inst 32'hF19F_F26F, OP_JAL -> 32'hFFFF_FF18.
  - inst 32'hFE41_04E3, OP_BRANCH -> 32'hFFFF_FFE8.
- Default/latency:
  - inst 32'hFFFF_FFFF, opcode 7'b0110011 -> 32'h0.
  - Switch inputs every cycle and check each result appears exactly one edge later.
  - Assert rst_ni mid-sequence and check the output clears without waiting for a clock edge.
